// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: captures the decoded control bundle, specifiers, operands and PC,
// inserts load-use bubbles, honours EX back-pressure and flush, and counts stalled cycles.
module id_ex_pipe #(
    parameter int DATA_W = 128,
    parameter int RA_W   = 4,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [3:0]        id_aluop,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_memtoreg,
    input  logic              id_regwrite,
    input  logic              id_jump,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [PC_W-1:0]   id_pc,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [3:0]        ex_aluop,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              ex_regwrite,
    output logic              ex_jump,
    output logic [RA_W-1:0]   ex_rs1,
    output logic [RA_W-1:0]   ex_rs2,
    output logic [RA_W-1:0]   ex_rd,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [PC_W-1:0]   ex_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [3:0] aluop;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       jump;
    } ctrl_t;

    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d, id_ctrl;
    logic [RA_W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, hazard;

    assign id_ctrl = '{aluop: id_aluop, memread: id_memread, memwrite: id_memwrite,
                       memtoreg: id_memtoreg, regwrite: id_regwrite, jump: id_jump};

    // An empty EX slot always accepts, regardless of ex_ready.
    assign accept   = ~valid_q | ex_ready;
    assign hazard   = id_valid & valid_q & ctrl_q.memread & ((rd_q == id_rs1) | (rd_q == id_rs2));
    assign id_stall = ~reset & ~flush & id_valid & (~accept | hazard);

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (accept) begin
            if (hazard) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end else begin
                // Data-side fields load even for an invalid ID slot; control stays quiet.
                valid_d = id_valid;
                ctrl_d  = id_valid ? id_ctrl : '0;
                rs1_d   = id_rs1;
                rs2_d   = id_rs2;
                rd_d    = id_rd;
                d1_d    = id_rs1_data;
                d2_d    = id_rs2_data;
                pc_d    = id_pc;
            end
        end
        if (id_stall && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_aluop    = ctrl_q.aluop;
    assign ex_memread  = ctrl_q.memread;
    assign ex_memwrite = ctrl_q.memwrite;
    assign ex_memtoreg = ctrl_q.memtoreg;
    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_jump     = ctrl_q.jump;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_rs1_data = d1_q;
    assign ex_rs2_data = d2_q;
    assign ex_pc       = pc_q;
    assign stall_cnt   = cnt_q;

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register sitting directly downstream of the opcode control decoder. It captures the decoded control bundle (aluop, memread, memwrite, memtoreg, regwrite, jump), the register specifiers, the operand data and the PC into the EX stage.
- Owns load-use interlock detection and bubble insertion.
- Honours EX back-pressure and jump-driven flush.
- Keeps a saturating stall counter for performance debug.

Parameters:
- DATA_W, 128, width of each vector operand data field.
- RA_W, 4, register specifier width.
- PC_W, 32, program counter width.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction this cycle.
- id_aluop  input  4  from control decoder.
- id_memread, id_memwrite, id_memtoreg, id_regwrite, id_jump  input  1 each  from control decoder.
- id_rs1, id_rs2, id_rd  input  RA_W each  register specifiers.
- id_rs1_data, id_rs2_data  input  DATA_W each  register file read data.
- id_pc  input  PC_W  PC of the ID instruction.
- flush  input  1  jump resolved in EX; kill the wrong-path instruction.
- ex_ready  input  1  EX can accept/advance this cycle.
- id_stall  output  1  hold fetch/decode (PC and IF/ID register) this cycle.
- ex_valid  output  1  EX register holds a real instruction.
- ex_aluop  output  4  registered control bundle.
- ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_jump  output  1 each  registered control bundle.
- ex_rs1, ex_rs2, ex_rd  output  RA_W each  registered specifiers.
- ex_rs1_data, ex_rs2_data  output  DATA_W each  registered operand data.
- ex_pc  output  PC_W  registered PC.
- stall_cnt  output  CNT_W  saturating count of stalled valid-ID cycles.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset: all ex_* outputs are 0, ex_valid is 0 and stall_cnt is 0. id_stall is combinational and evaluates to 0 while reset is high.
- Latency: one cycle from ID inputs to ex_* outputs.
- Hazard (combinational): hazard = id_valid & ex_valid & ex_memread & (ex_rd == id_rs1 | ex_rd == id_rs2). Register 0 gets no special treatment.
- accept = ~ex_valid | ex_ready. An empty EX slot always accepts, even when ex_ready = 0.
- id_stall = ~flush & id_valid & (~accept | hazard).
- Per-edge update, first matching rule wins:
  1. reset: clear all state.
  2. flush: load a bubble; the ID instruction is discarded, not held.
  3. ~accept: hold every ex_* output unchanged.
  4. hazard: load a bubble; the ID instruction is held upstream via id_stall.
  5. otherwise: load all id_* fields, with ex_valid = id_valid.
- Bubble definition:
  - ex_valid = 0.
  - ex_aluop = 0; ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite and ex_jump all = 0.
  - Specifier, data and PC fields keep their previous values.
- Loading with id_valid = 0 behaves as a bubble for control fields and ex_valid; data, specifier and PC fields load normally.
- Interlock length: a load-use hazard costs exactly one bubble. In the next cycle ex_valid = 0, so the hazard deasserts and the held instruction loads.
- Nop opcode: the decoder outputs all-zero control. It still passes through as ex_valid = 1 when id_valid = 1.
- stall_cnt: increments on each edge where id_stall = 1. It saturates at all-ones and never wraps. It is cleared only by reset.
- Simultaneous events:
  - flush with ~accept: flush wins and EX is emptied.
  - flush with hazard: flush wins; id_stall = 0.
  - hazard with ~accept: hold wins; id_stall = 1; stall_cnt increments once per cycle.
- Reset mid-operation: reset overrides all inputs in the same edge. A held or stalled instruction is lost.

Test Plan:
- Straight flow: add (aluop 0000, regwrite 1) with id_rd = 3, id_pc = 0x10, ex_ready = 1 -> next cycle ex_valid = 1, ex_aluop = 0000, ex_regwrite = 1, ex_rd = 3, ex_pc = 0x10; id_stall stays 0.
- Load-use: ldv to rd = 5 in EX, then ID sub with rs2 = 5 -> id_stall = 1 for exactly one cycle and a bubble enters EX (ex_valid = 0, all control 0). The sub loads on the following edge; stall_cnt = 1.
- Back-pressure: EX holds a valid eor, ex_ready = 0 for 3 cycles -> ex_* outputs are unchanged, id_stall = 1 for 3 cycles, stall_cnt += 3. When ex_ready = 1 the next ID instruction loads.
- Flush priority: cmpj in EX, assert flush together with ex_ready = 0 and a hazard present -> next cycle ex_valid = 0 and ex_jump = 0; id_stall = 0 during the flush cycle; stall_cnt unchanged.
- Saturation: force 65540 stalled cycles -> stall_cnt reaches 0xFFFF and holds there; a subsequent reset returns it to 0.
- Reset mid-stall: assert reset during a hazard stall -> next cycle all ex_* outputs are 0, ex_valid = 0, stall_cnt = 0; id_stall = 0 while reset is high.
